// File: rtl/cla_result_accumulator_pkg.sv
// Shared definitions for the CLA result accumulator.
// Holds the state encodings and the CLA result word width. The CLA wrapper
// and this block both use the result width.
package cla_result_accumulator_pkg;

    // Width of a CLA result word {c_out, sum[3:0]}
    localparam int unsigned CLA_RES_W = 5;

    // Accumulator FSM states
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage : cla_result_accumulator_pkg

// File: rtl/cla_result_accumulator_sat_add.sv
// Combinational saturating adder: y = min(a + b, 2^W-1).
// Ports:
//   a   - W-bit running total
//   b   - CLA result word, zero-extended before the add
//   y   - saturated sum
//   sat - high when the unsaturated sum exceeds 2^W-1
module sat_add
    import cla_result_accumulator_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0]         a,
    input  logic [CLA_RES_W-1:0] b,
    output logic [W-1:0]         y,
    output logic                 sat
);

    logic [W:0] sum_full;

    // One extra bit catches the carry out of the W-bit total
    assign sum_full = {1'b0, a} + (W+1)'(b);
    assign sat      = sum_full[W];
    assign y        = sat ? {W{1'b1}} : sum_full[W-1:0];

endmodule : sat_add

// File: rtl/cla_result_accumulator.sv
// Frame accumulator for CLA result words.
// Sums FRAME_LEN accepted samples (or fewer when flush closes the frame early)
// into a saturating ACC_W-bit total, then holds the result until it is taken.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_data/valid/ready - CLA result word input handshake
//   flush               - close the current non-empty frame early
//   out_sum/count/ovf   - frame total, sample count, saturation flag
//   out_valid/ready     - output handshake
module cla_result_accumulator
    import cla_result_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CLA_RES_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [ACC_W-1:0]     out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic               accept;
    logic [ACC_W-1:0]   add_y;
    logic               add_sat;
    logic [CNT_W:0]     cnt_inc;
    logic [ACC_W-1:0]   acc_upd;
    logic [CNT_W-1:0]   cnt_upd;
    logic               ovf_upd;
    logic               close;

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (in_data),
        .y   (add_y),
        .sat (add_sat)
    );

    // in_ready_q is only ever high in ACCUM, so it alone qualifies an accept
    assign accept  = in_valid & in_ready_q;
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    // Frame state as it would be after this cycle's sample, before any close
    assign acc_upd = accept ? add_y : acc_q;
    assign cnt_upd = accept ? cnt_inc[CNT_W-1:0] : cnt_q;
    assign ovf_upd = ovf_q | (accept & add_sat);
    assign close   = (accept && (cnt_inc == (CNT_W+1)'(FRAME_LEN)))
                   || (flush && ((cnt_q != '0) || accept));

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ACCUM: begin
                if (close) begin
                    out_sum_d   = acc_upd;
                    out_count_d = cnt_upd;
                    out_ovf_d   = ovf_upd;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    acc_d = acc_upd;
                    cnt_d = cnt_upd;
                    ovf_d = ovf_upd;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        in_ready_d = (state_d == ST_ACCUM);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

endmodule : cla_result_accumulator

// File: tb/tb_cla_result_accumulator.sv
// Scoreboard bench: dut_a uses default parameters, dut_b is an
// ACC_W=8 / FRAME_LEN=16 / CNT_W=5 instance for the saturation frame.
module tb_cla_result_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic [4:0] in_data;
    logic       in_valid;
    logic       flush;
    logic       out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [11:0] out_sum_a;
    logic [3:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [7:0]  out_sum_b;
    logic [4:0]  out_count_b;

    logic in_ready_m, out_valid_m;
    int   out_sum_m;

    typedef struct {
        int sum;
        int cnt;
        int ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_result_accumulator #(.ACC_W(12), .FRAME_LEN(8), .CNT_W(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid & ~sel),
        .in_ready  (in_ready_a),
        .flush     (flush & ~sel),
        .out_sum   (out_sum_a),
        .out_count (out_count_a),
        .out_ovf   (out_ovf_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready & ~sel)
    );

    cla_result_accumulator #(.ACC_W(8), .FRAME_LEN(16), .CNT_W(5)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid & sel),
        .in_ready  (in_ready_b),
        .flush     (flush & sel),
        .out_sum   (out_sum_b),
        .out_count (out_count_b),
        .out_ovf   (out_ovf_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready & sel)
    );

    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign out_sum_m   = sel ? int'(out_sum_b) : int'(out_sum_a);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int c, input int o);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    // Monitors: compare on every output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready && !sel) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_frame", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_out_sum", int'(out_sum_a), e.sum);
                chk("a_out_count", int'(out_count_a), e.cnt);
                chk("a_out_ovf", int'(out_ovf_a), e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_b && out_ready && sel) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_frame", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_out_sum", int'(out_sum_b), e.sum);
                chk("b_out_count", int'(out_count_b), e.cnt);
                chk("b_out_ovf", int'(out_ovf_b), e.ovf);
            end
        end
    end

    // Offer one sample (optionally with flush) and hold it until accepted
    task automatic send(input logic [4:0] d, input logic fl);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        @(negedge clk);
        while (!in_ready_m && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Take one output frame; the monitor checks its contents
    task automatic drain();
        int t = 0;
        while (!out_valid_m && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_valid", int'(out_valid_m), 1);
        chk("drain_in_ready_low", int'(in_ready_m), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_valid_cleared", int'(out_valid_m), 0);
        chk("drain_in_ready_back", int'(in_ready_m), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #3;
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out_sum", int'(out_sum_a), 0);
        chk("rst_out_count", int'(out_count_a), 0);
        chk("rst_in_ready", int'(in_ready_a), 0);
        #14;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", int'(in_ready_a), 1);

        // Full default frame
        for (int i = 0; i < 8; i++) send(5'd3, 1'b0);
        push(24, 8, 0);
        drain();

        // Flush alone, then flush together with a sample
        for (int i = 0; i < 3; i++) send(5'd10, 1'b0);
        pulse_flush();
        push(30, 3, 0);
        drain();
        for (int i = 0; i < 3; i++) send(5'd10, 1'b0);
        send(5'd7, 1'b1);
        push(37, 4, 0);
        drain();

        // Flush on an empty frame emits nothing
        pulse_flush();
        idle(3);
        chk("empty_flush_no_valid", int'(out_valid_a), 0);

        // Backpressure: HOLD ignores in_valid and flush
        for (int i = 0; i < 5; i++) send(5'd2, 1'b0);
        pulse_flush();
        push(10, 5, 0);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_data  = 5'd31;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", int'(out_valid_a), 1);
            chk("bp_sum", int'(out_sum_a), 10);
            chk("bp_in_ready", int'(in_ready_a), 0);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();
        send(5'd4, 1'b0);
        send(5'd4, 1'b1);
        push(8, 2, 0);
        drain();

        // Async reset mid-frame
        for (int i = 0; i < 5; i++) send(5'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mid_in_ready", int'(in_ready_a), 0);
        chk("arst_mid_valid", int'(out_valid_a), 0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Async reset while holding an untaken frame
        for (int i = 0; i < 8; i++) send(5'd2, 1'b0);
        chk("hold_before_rst", int'(out_valid_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hold_valid", int'(out_valid_a), 0);
        chk("arst_hold_sum", int'(out_sum_a), 0);
        chk("arst_hold_count", int'(out_count_a), 0);
        chk("arst_hold_in_ready", int'(in_ready_a), 0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send(5'd1, 1'b0);
        push(8, 8, 0);
        drain();

        // Gapped input
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 3));
            send(5'd31, 1'b0);
        end
        push(248, 8, 0);
        drain();

        // Saturation on the wide-frame instance
        sel = 1'b1;
        idle(1);
        for (int i = 0; i < 16; i++) send(5'd31, 1'b0);
        push(255, 16, 1);
        drain();
        send(5'd1, 1'b0);
        send(5'd1, 1'b1);
        push(2, 2, 0);
        drain();

        idle(2);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        chk("final_a_valid", int'(out_valid_a), 0);
        chk("final_b_sum_held", out_sum_m, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_cla_result_accumulator
